// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
//
// Purpose:
//   Fetch/decode pipeline stage. It latches an instruction word and its PC
//   into a valid-tagged instruction register (IR), with stall, flush and
//   ready handshakes. From the IR it produces the sequential, jump and branch
//   PC targets, the decoded instruction fields and the register-file read
//   addresses.
//
// Optional build macro:
//   FD_DECODE_REG_EN - when defined, the decoded outputs and PC targets get
//   their own register stage, tagged by dec_valid (latency N+2). When it is
//   undefined they are combinational from the IR (latency N+1).
//
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-high reset
//   imem_data/pc   - instruction word and its PC from instruction memory
//   imem_valid     - imem_data/imem_pc are valid this cycle
//   imem_ready     - the stage accepts imem_data this cycle
//   stall, flush   - downstream hold request / squash the IR contents
//   addrbase       - addr1 source select (0:R0, 1:rs, 2:addr2, 3:rs)
//   mulreg         - LSB of addr2
//   ir_valid, ir, ir_pc - instruction register contents
//   pc_seq, pc_jump, pc_branch - next-PC candidates
//   opcode, func, offset, rdest_bit0 - decoded instruction fields
//   addr1, addr2   - register-file read addresses
//   dec_valid      - decode register valid (FD_DECODE_REG_EN only)
//   stall_cnt      - saturating count of stalled cycles holding a live IR

module fetch_decode_stage #(
    parameter int DW      = 16,
    parameter int REG_AW  = 4,
    parameter int PC_STEP = 2,
    parameter int IMM_W   = 8,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DW-1:0]     imem_data,
    input  logic              imem_valid,
    input  logic [DW-1:0]     imem_pc,
    output logic              imem_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [1:0]        addrbase,
    input  logic              mulreg,
    output logic              ir_valid,
    output logic [DW-1:0]     ir,
    output logic [DW-1:0]     ir_pc,
    output logic [DW-1:0]     pc_seq,
    output logic [DW-1:0]     pc_jump,
    output logic [DW-1:0]     pc_branch,
    output logic [4:0]        opcode,
    output logic [2:0]        func,
    output logic [DW-6:0]     offset,
    output logic              rdest_bit0,
    output logic [REG_AW-1:0] addr1,
    output logic [REG_AW-1:0] addr2,
`ifdef FD_DECODE_REG_EN
    output logic              dec_valid,
`endif
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   load;

    // The stage can take a word whenever it is empty or the downstream is
    // not holding it; a flush overrides any acceptance that cycle.
    assign ir_valid   = (state == FULL);
    assign imem_ready = !ir_valid || !stall;

    // State register for the EMPTY/FULL occupancy of the IR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and load enable. Flush wins over everything and drops any
    // word presented in the same cycle; otherwise an accepted word always
    // loads, a stalled FULL stage holds, and a FULL stage with nothing new
    // drains to EMPTY.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else if (imem_valid && imem_ready) begin
            load       = 1'b1;
            state_next = FULL;
        end else if (state == FULL && stall) begin
            state_next = FULL;
        end else begin
            state_next = EMPTY;
        end
    end

    // Instruction register and its PC. They only change on a load, so the
    // decoded outputs stay deterministic while the stage is EMPTY.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir    <= '0;
            ir_pc <= '0;
        end else if (load) begin
            ir    <= imem_data;
            ir_pc <= imem_pc;
        end
    end

    // Stall counter: counts cycles in which a live instruction is held by
    // stall (and not squashed). It sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (ir_valid && stall && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Decode of the IR contents.
    logic [DW-1:0]     imm_ext;
    logic [DW-1:0]     seq_c;
    logic [DW-1:0]     jump_c;
    logic [DW-1:0]     branch_c;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] addr1_c;
    logic [REG_AW-1:0] addr2_c;

    // Branch displacement is a signed halfword count, hence the shift by one.
    assign imm_ext  = {{(DW-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign seq_c    = ir_pc + DW'(PC_STEP);
    assign jump_c   = {ir_pc[DW-1:DW-2], ir[DW-4:0], 1'b0};
    assign branch_c = ir_pc + (imm_ext << 1);
    assign rs       = ir[3+REG_AW-1:3];
    assign addr2_c  = {ir[8+REG_AW-2:8], mulreg};

    // Read address 1 source select; codes 1 and 3 both pick rs.
    always_comb begin
        addr1_c = '0;
        case (addrbase)
            2'd0: addr1_c = '0;
            2'd1: addr1_c = rs;
            2'd2: addr1_c = addr2_c;
            2'd3: addr1_c = rs;
        endcase
    end

`ifdef FD_DECODE_REG_EN
    // Registered decode stage. It follows the same rules as the IR one stage
    // later: flush empties it, stall holds it, otherwise it takes whatever
    // the IR holds (live or not) along with the IR valid bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_valid  <= 1'b0;
            pc_seq     <= '0;
            pc_jump    <= '0;
            pc_branch  <= '0;
            opcode     <= '0;
            func       <= '0;
            offset     <= '0;
            rdest_bit0 <= 1'b0;
            addr1      <= '0;
            addr2      <= '0;
        end else if (flush) begin
            dec_valid  <= 1'b0;
        end else if (!stall) begin
            dec_valid  <= ir_valid;
            pc_seq     <= seq_c;
            pc_jump    <= jump_c;
            pc_branch  <= branch_c;
            opcode     <= ir[DW-1:DW-5];
            func       <= ir[2:0];
            offset     <= ir[DW-6:0];
            rdest_bit0 <= ir[7];
            addr1      <= addr1_c;
            addr2      <= addr2_c;
        end
    end
`else
    assign pc_seq     = seq_c;
    assign pc_jump    = jump_c;
    assign pc_branch  = branch_c;
    assign opcode     = ir[DW-1:DW-5];
    assign func       = ir[2:0];
    assign offset     = ir[DW-6:0];
    assign rdest_bit0 = ir[7];
    assign addr1      = addr1_c;
    assign addr2      = addr2_c;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb_fetch_decode_stage
//
// Purpose:
//   Self-checking bench for fetch_decode_stage (default build, CNT_W=2 so
//   the stall counter saturates quickly). Each stimulus step drives the
//   inputs just after a rising edge and queues the hand-computed outputs the
//   stage must show during that cycle; a monitor pops and compares them at
//   the following falling edge.

module tb_fetch_decode_stage;

    logic        clock;
    logic        reset;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] imem_pc;
    logic        imem_ready;
    logic        stall;
    logic        flush;
    logic [1:0]  addrbase;
    logic        mulreg;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic [15:0] pc_seq;
    logic [15:0] pc_jump;
    logic [15:0] pc_branch;
    logic [4:0]  opcode;
    logic [2:0]  func;
    logic [10:0] offset;
    logic        rdest_bit0;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [1:0]  stall_cnt;

    fetch_decode_stage #(
        .DW(16), .REG_AW(4), .PC_STEP(2), .IMM_W(8), .CNT_W(2)
    ) dut (
        .clock(clock), .reset(reset),
        .imem_data(imem_data), .imem_valid(imem_valid), .imem_pc(imem_pc),
        .imem_ready(imem_ready), .stall(stall), .flush(flush),
        .addrbase(addrbase), .mulreg(mulreg),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
        .pc_seq(pc_seq), .pc_jump(pc_jump), .pc_branch(pc_branch),
        .opcode(opcode), .func(func), .offset(offset), .rdest_bit0(rdest_bit0),
        .addr1(addr1), .addr2(addr2), .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        valid;
        logic        ready;
        logic [1:0]  cnt;
        logic        chk_ir;
        logic [15:0] ir;
        logic [15:0] ir_pc;
        logic [15:0] seq;
        logic [15:0] jump;
        logic [15:0] branch;
        logic [4:0]  op;
        logic [2:0]  fn;
        logic        chk_addr;
        logic [3:0]  a1;
        logic [3:0]  a2;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    // Base expectation: occupancy, handshake and stall counter.
    function automatic exp_t st(string n, logic v, logic r, logic [1:0] c);
        exp_t e;
        e.name = n; e.valid = v; e.ready = r; e.cnt = c;
        e.chk_ir = 1'b0; e.ir = '0; e.ir_pc = '0; e.seq = '0; e.jump = '0;
        e.branch = '0; e.op = '0; e.fn = '0;
        e.chk_addr = 1'b0; e.a1 = '0; e.a2 = '0;
        return e;
    endfunction

    // Adds IR contents and the decoded PC targets/fields to an expectation.
    function automatic exp_t dec(exp_t b, logic [15:0] i, logic [15:0] p,
                                 logic [15:0] s, logic [15:0] j,
                                 logic [15:0] br, logic [4:0] o, logic [2:0] f);
        exp_t e = b;
        e.chk_ir = 1'b1; e.ir = i; e.ir_pc = p; e.seq = s; e.jump = j;
        e.branch = br; e.op = o; e.fn = f;
        return e;
    endfunction

    // Adds the register read addresses to an expectation.
    function automatic exp_t adr(exp_t b, logic [3:0] x1, logic [3:0] x2);
        exp_t e = b;
        e.chk_addr = 1'b1; e.a1 = x1; e.a2 = x2;
        return e;
    endfunction

    // One comparison: counts it, and reports it when it does not match.
    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end else begin
            passed++;
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and queues what
    // the stage must show during that cycle.
    task automatic applyStimulus(logic rst, logic v, logic [15:0] d, logic [15:0] p,
                                 logic stl, logic fl, logic [1:0] ab, logic mr,
                                 exp_t e);
        @(posedge clock);
        #1;
        reset      = rst;
        imem_valid = v;
        imem_data  = d;
        imem_pc    = p;
        stall      = stl;
        flush      = fl;
        addrbase   = ab;
        mulreg     = mr;
        sb.push_back(e);
    endtask

    // Monitor: at each falling edge, compare against the oldest queued
    // expectation, if any.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput({e.name, ".ir_valid"}, 32'(ir_valid), 32'(e.valid));
                checkOutput({e.name, ".imem_ready"}, 32'(imem_ready), 32'(e.ready));
                checkOutput({e.name, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
                if (e.chk_ir) begin
                    checkOutput({e.name, ".ir"}, 32'(ir), 32'(e.ir));
                    checkOutput({e.name, ".ir_pc"}, 32'(ir_pc), 32'(e.ir_pc));
                    checkOutput({e.name, ".pc_seq"}, 32'(pc_seq), 32'(e.seq));
                    checkOutput({e.name, ".pc_jump"}, 32'(pc_jump), 32'(e.jump));
                    checkOutput({e.name, ".pc_branch"}, 32'(pc_branch), 32'(e.branch));
                    checkOutput({e.name, ".opcode"}, 32'(opcode), 32'(e.op));
                    checkOutput({e.name, ".func"}, 32'(func), 32'(e.fn));
                end
                if (e.chk_addr) begin
                    checkOutput({e.name, ".addr1"}, 32'(addr1), 32'(e.a1));
                    checkOutput({e.name, ".addr2"}, 32'(addr2), 32'(e.a2));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; imem_valid = 1'b0; imem_data = '0; imem_pc = '0;
        stall = 1'b0; flush = 1'b0; addrbase = 2'd0; mulreg = 1'b0;

        // Reset state.
        applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0,
            adr(dec(st("rst", 0, 1, 0), 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 5'h00, 3'd0), 4'd0, 4'd0));

        // First load and its decode one cycle later.
        applyStimulus(0, 1, 16'h8A5B, 16'h0100, 0, 0, 2'd0, 0, st("ld0", 0, 1, 0));
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0,
            adr(dec(st("dec0", 1, 1, 0), 16'h8A5B, 16'h0100, 16'h0102, 16'h14B6, 16'h01B6, 5'h11, 3'd3), 4'd0, 4'd4));

        // Negative branch immediate, then PC wrap, back-to-back.
        applyStimulus(0, 1, 16'h00FE, 16'h0010, 0, 0, 2'd0, 0, st("ld1", 0, 1, 0));
        applyStimulus(0, 1, 16'h0000, 16'hFFFE, 0, 0, 2'd0, 0,
            dec(st("negbr", 1, 1, 0), 16'h00FE, 16'h0010, 16'h0012, 16'h01FC, 16'h000C, 5'h00, 3'd6));
        applyStimulus(0, 1, 16'h0538, 16'h0200, 0, 0, 2'd0, 1,
            adr(dec(st("wrap", 1, 1, 0), 16'h0000, 16'hFFFE, 16'h0000, 16'hC000, 16'hFFFE, 5'h00, 3'd0), 4'd0, 4'd1));

        // Address-select sweep with the same word reloaded each cycle.
        for (int ab = 0; ab < 4; ab++) begin
            logic [3:0] a1_req;
            a1_req = (ab == 0) ? 4'd0 : (ab == 2) ? 4'd11 : 4'd7;
            applyStimulus(0, 1, 16'h0538, 16'h0200, 0, 0, 2'(ab), 1,
                adr(dec(st($sformatf("sweep%0d", ab), 1, 1, 0), 16'h0538, 16'h0200, 16'h0202, 16'h0A70, 16'h0270, 5'h00, 3'd0), a1_req, 4'd11));
        end

        // Stall for three cycles while a different word is offered.
        applyStimulus(0, 1, 16'h1234, 16'h0300, 1, 0, 2'd0, 0,
            adr(dec(st("stl0", 1, 0, 0), 16'h0538, 16'h0200, 16'h0202, 16'h0A70, 16'h0270, 5'h00, 3'd0), 4'd0, 4'd10));
        applyStimulus(0, 1, 16'h1234, 16'h0300, 1, 0, 2'd0, 0,
            dec(st("stl1", 1, 0, 1), 16'h0538, 16'h0200, 16'h0202, 16'h0A70, 16'h0270, 5'h00, 3'd0));
        applyStimulus(0, 1, 16'h1234, 16'h0300, 1, 0, 2'd0, 0,
            dec(st("stl2", 1, 0, 2), 16'h0538, 16'h0200, 16'h0202, 16'h0A70, 16'h0270, 5'h00, 3'd0));
        applyStimulus(0, 1, 16'h1234, 16'h0300, 0, 0, 2'd0, 0,
            dec(st("stlrel", 1, 1, 3), 16'h0538, 16'h0200, 16'h0202, 16'h0A70, 16'h0270, 5'h00, 3'd0));
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0,
            dec(st("stlnew", 1, 1, 3), 16'h1234, 16'h0300, 16'h0302, 16'h2468, 16'h0368, 5'h02, 3'd4));

        // Flush together with a valid word: the word must be dropped.
        applyStimulus(0, 1, 16'h4444, 16'h0400, 0, 0, 2'd0, 0, st("ld2", 0, 1, 3));
        applyStimulus(0, 1, 16'h5555, 16'h0500, 0, 1, 2'd0, 0,
            dec(st("fl", 1, 1, 3), 16'h4444, 16'h0400, 16'h0402, 16'h0888, 16'h0488, 5'h08, 3'd4));
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0,
            dec(st("flpost", 0, 1, 3), 16'h4444, 16'h0400, 16'h0402, 16'h0888, 16'h0488, 5'h08, 3'd4));

        // Flush during stall empties the stage.
        applyStimulus(0, 1, 16'h6666, 16'h0600, 0, 0, 2'd0, 0, st("ld3", 0, 1, 3));
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 2'd0, 0, st("flstl", 1, 0, 3));
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, st("flstlpost", 0, 1, 3));

        // Reset, then saturate the 2-bit counter, then reset mid-stall.
        applyStimulus(1, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, st("rst2", 0, 1, 0));
        applyStimulus(0, 1, 16'h0538, 16'h0200, 0, 0, 2'd0, 0, st("ld4", 0, 1, 0));
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 16'h1111, 16'h0900, 1, 0, 2'd0, 0,
                st($sformatf("sat%0d", k), 1, 0, (k < 3) ? 2'(k) : 2'd3));
        end
        applyStimulus(1, 1, 16'h1111, 16'h0900, 1, 0, 2'd0, 0, st("rststl", 0, 1, 0));
        applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 2'd0, 0,
            dec(st("rstpost", 0, 1, 0), 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 5'h00, 3'd0));

        // Let the monitor drain the queue, bounded.
        for (int w = 0; w < 10 && sb.size() != 0; w++) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            total++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
